// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - request/response and memory-strobe bundle for the two-port data memory arbiter
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_memWrite;
    logic              mem_memRead;
    logic [DATA_W-1:0] mem_writeData;
    logic [DATA_W-1:0] mem_readData;

    // Requesters plus the memory model: drives requests and read data.
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_address, mem_memWrite, mem_memRead, mem_writeData,
        output mem_readData
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_address, mem_memWrite, mem_memRead, mem_writeData,
        input  mem_readData
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin arbiter sharing one data memory between CPU and debug ports
module dmem_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;

    state_t            r_state;
    logic              r_rr_last;
    logic              r_port;
    logic              r_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic              r_mem_write;
    logic              r_mem_read;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_rsp_valid;
    logic [1:0]        r_rsp_err;
    logic [DATA_W-1:0] r_rsp0_rdata;
    logic [DATA_W-1:0] r_rsp1_rdata;

    logic              w_arb_en;
    logic              w_g0;
    logic              w_g1;
    logic              w_hs;
    logic              w_sel;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_misal;

    // Reset takes effect at once but is released only on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // Arbitration is open in IDLE and RESP, so a new handshake can overlap a response.
    assign w_arb_en    = w_rst_n && (r_state != S_ISSUE);
    assign w_g0        = w_arb_en && bus.req0_valid && (!bus.req1_valid || r_rr_last);
    assign w_g1        = w_arb_en && bus.req1_valid && (!bus.req0_valid || !r_rr_last);
    assign w_hs        = w_g0 | w_g1;
    assign w_sel       = w_g1;
    assign w_sel_write = w_sel ? bus.req1_write : bus.req0_write;
    assign w_sel_addr  = w_sel ? bus.req1_addr  : bus.req0_addr;
    assign w_sel_wdata = w_sel ? bus.req1_wdata : bus.req0_wdata;
    assign w_misal     = |w_sel_addr[1:0];

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= S_IDLE;
            r_rr_last     <= 1'b1;
            r_port        <= 1'b0;
            r_write       <= 1'b0;
            r_mem_address <= '0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_wdata   <= '0;
            r_rsp_valid   <= 2'b00;
            r_rsp_err     <= 2'b00;
            r_rsp0_rdata  <= '0;
            r_rsp1_rdata  <= '0;
        end else begin
            r_mem_address <= '0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_wdata   <= '0;
            r_rsp_valid   <= 2'b00;
            r_rsp_err     <= 2'b00;
            r_rsp0_rdata  <= '0;
            r_rsp1_rdata  <= '0;

            if (r_state == S_ISSUE) begin
                // The memory's negedge read has settled by this edge.
                r_state              <= S_RESP;
                r_rsp_valid[r_port]  <= 1'b1;
                if (!r_write) begin
                    if (r_port) r_rsp1_rdata <= bus.mem_readData;
                    else        r_rsp0_rdata <= bus.mem_readData;
                end
            end else if (w_hs) begin
                r_port    <= w_sel;
                r_write   <= w_sel_write;
                r_rr_last <= w_sel;
                if (w_misal) begin
                    r_state            <= S_RESP;
                    r_rsp_valid[w_sel] <= 1'b1;
                    r_rsp_err[w_sel]   <= 1'b1;
                end else begin
                    r_state       <= S_ISSUE;
                    r_mem_address <= w_sel_addr;
                    r_mem_write   <= w_sel_write;
                    r_mem_read    <= !w_sel_write;
                    r_mem_wdata   <= w_sel_write ? w_sel_wdata : '0;
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    assign bus.req0_ready    = w_g0;
    assign bus.req1_ready    = w_g1;
    assign bus.rsp0_valid    = r_rsp_valid[0];
    assign bus.rsp0_err      = r_rsp_err[0];
    assign bus.rsp0_rdata    = r_rsp0_rdata;
    assign bus.rsp1_valid    = r_rsp_valid[1];
    assign bus.rsp1_err      = r_rsp_err[1];
    assign bus.rsp1_rdata    = r_rsp1_rdata;
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_memWrite  = r_mem_write;
    assign bus.mem_memRead   = r_mem_read;
    assign bus.mem_writeData = r_mem_wdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [7:0] init_byte(input int i);
        if (i == 16) return 8'h02;
        if (i >= 17 && i <= 19) return 8'h00;
        return 8'(i + 16);
    endfunction

    // Memory device: writes on posedge, reads on negedge, little-endian bytes.
    logic       mem_load;
    logic [7:0] dev_mem [32];
    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) dev_mem[i] <= init_byte(i);
        end else if (bus.mem_memWrite) begin
            for (int b = 0; b < 4; b++)
                dev_mem[5'(bus.mem_address + 5'(b))] <= bus.mem_writeData[8*b +: 8];
        end
    end
    always @(negedge clock) begin
        if (bus.mem_memRead)
            bus.mem_readData <= {dev_mem[bus.mem_address + 5'd3], dev_mem[bus.mem_address + 5'd2],
                                 dev_mem[bus.mem_address + 5'd1], dev_mem[bus.mem_address]};
    end

    // Reference model: serialised request stream against a byte array.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic [7:0] ref_mem [32];
    exp_t       q [2][$];
    int         cyc = 0;
    int         rsp_cnt [2];
    int         last_grant = 1;
    logic       mon_en;
    logic       mon_clear;

    function automatic logic [31:0] ref_word(input logic [4:0] a);
        return {ref_mem[a + 5'd3], ref_mem[a + 5'd2], ref_mem[a + 5'd1], ref_mem[a]};
    endfunction

    task automatic mon_rsp(input int p, input logic rv, input logic [31:0] rd, input logic er);
        exp_t e;
        if (!rv) return;
        rsp_cnt[p]++;
        if (q[p].size() == 0) begin
            chk($sformatf("rsp%0d_unexpected", p), 32'd1, 32'd0);
            return;
        end
        e = q[p].pop_front();
        chk($sformatf("rsp%0d_rdata", p), rd, e.rdata);
        chk($sformatf("rsp%0d_err", p), {31'd0, er}, {31'd0, e.err});
        chk($sformatf("rsp%0d_cycle", p), cyc, e.due);
    endtask

    task automatic mon_hs(input int p, input logic wr, input logic [4:0] a, input logic [31:0] d,
                          input logic contested);
        exp_t e;
        if (contested) chk("rr_grant", p, 1 - last_grant);
        last_grant = p;
        e.due = cyc + ((a[1:0] != 2'b00) ? 1 : 2);
        if (a[1:0] != 2'b00) begin
            e.rdata = 32'd0; e.err = 1'b1;
        end else if (wr) begin
            for (int b = 0; b < 4; b++) ref_mem[5'(a + 5'(b))] = d[8*b +: 8];
            e.rdata = 32'd0; e.err = 1'b0;
        end else begin
            e.rdata = ref_word(a); e.err = 1'b0;
        end
        q[p].push_back(e);
    endtask

    task automatic mon_step();
        logic hs0, hs1;
        cyc++;
        if (mem_load) for (int i = 0; i < 32; i++) ref_mem[i] = init_byte(i);
        if (mon_clear) begin
            q[0].delete(); q[1].delete(); last_grant = 1;
        end
        if (!mon_en) return;
        if (bus.mem_memWrite || bus.mem_memRead)
            chk("strobe_exclusive", {31'd0, bus.mem_memWrite & bus.mem_memRead}, 32'd0);
        if (bus.rsp1_valid) begin
            chk("rsp0_quiet_rdata", bus.rsp0_rdata, 32'd0);
            chk("rsp0_quiet_err", {31'd0, bus.rsp0_err}, 32'd0);
        end
        if (bus.rsp0_valid) begin
            chk("rsp1_quiet_rdata", bus.rsp1_rdata, 32'd0);
            chk("rsp1_quiet_err", {31'd0, bus.rsp1_err}, 32'd0);
        end
        mon_rsp(0, bus.rsp0_valid, bus.rsp0_rdata, bus.rsp0_err);
        mon_rsp(1, bus.rsp1_valid, bus.rsp1_rdata, bus.rsp1_err);
        hs0 = bus.req0_valid && bus.req0_ready;
        hs1 = bus.req1_valid && bus.req1_ready;
        if (hs0 || hs1) chk("ready_one_port", {31'd0, hs0 & hs1}, 32'd0);
        if (hs0) mon_hs(0, bus.req0_write, bus.req0_addr, bus.req0_wdata, bus.req1_valid);
        if (hs1) mon_hs(1, bus.req1_write, bus.req1_addr, bus.req1_wdata, bus.req0_valid);
    endtask

    always @(negedge clock) mon_step();

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic set_req(input int p, input logic v, input logic wr, input logic [4:0] a,
                           input logic [31:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    // Holds the request until accepted; returns one time unit after the accepting edge.
    task automatic drive_req(input int p, input logic wr, input logic [4:0] a, input logic [31:0] d,
                             output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        set_req(p, 1'b1, wr, a, d);
        while (!got && waited < 30) begin
            @(negedge clock);
            waited++;
            got = (p == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
            @(posedge clock); #1;
        end
        set_req(p, 1'b0, wr, a, d);
        if (!got) chk($sformatf("hs%0d_timeout", p), 32'd0, 32'd1);
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nw;
        int          exp_nr;
    } vec_t;

    task automatic run_single(input vec_t v, output logic [31:0] rd, output logic er, output int lat,
                              output int nw, output int nr, output logic [4:0] sa, output int other);
        int w;
        rd = 32'd0; er = 1'b0; lat = 0; nw = 0; nr = 0; sa = 5'd0; other = 0;
        drive_req(v.port, v.wr, v.addr, v.wdata, w);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (bus.mem_memWrite) begin nw++; sa = bus.mem_address; end
            if (bus.mem_memRead)  begin nr++; sa = bus.mem_address; end
            if ((v.port == 0) ? bus.rsp1_valid : bus.rsp0_valid) other++;
            if ((v.port == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
                lat = i;
                rd  = (v.port == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
                er  = (v.port == 0) ? bus.rsp0_err : bus.rsp1_err;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        vec_t        tbl [12];
        logic [31:0] rd;
        logic        er;
        int          lat, nw, nr, oth, w0, w1, n, c0, c1;
        logic [4:0]  sa;
        int          gp [$];
        int          gc [$];

        tbl[0]  = '{0, 1'b1, 5'd4,  32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 0};
        tbl[1]  = '{0, 1'b0, 5'd4,  32'h00000000, 32'hDEADBEEF, 1'b0, 2, 0, 1};
        tbl[2]  = '{0, 1'b0, 5'd16, 32'h00000000, 32'h00000002, 1'b0, 2, 0, 1};
        tbl[3]  = '{1, 1'b0, 5'd6,  32'h00000000, 32'h00000000, 1'b1, 1, 0, 0};
        tbl[4]  = '{1, 1'b0, 5'd28, 32'h00000000, 32'h2F2E2D2C, 1'b0, 2, 0, 1};
        tbl[5]  = '{1, 1'b1, 5'd28, 32'hA5A55A5A, 32'h00000000, 1'b0, 2, 1, 0};
        tbl[6]  = '{0, 1'b0, 5'd28, 32'h00000000, 32'hA5A55A5A, 1'b0, 2, 0, 1};
        tbl[7]  = '{0, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0, 0};
        tbl[8]  = '{1, 1'b0, 5'd0,  32'h00000000, 32'h13121110, 1'b0, 2, 0, 1};
        tbl[9]  = '{0, 1'b0, 5'd1,  32'h00000000, 32'h00000000, 1'b1, 1, 0, 0};
        tbl[10] = '{1, 1'b1, 5'd8,  32'h01234567, 32'h00000000, 1'b0, 2, 1, 0};
        tbl[11] = '{0, 1'b0, 5'd12, 32'h00000000, 32'h1F1E1D1C, 1'b0, 2, 0, 1};

        reset_n = 1'b0; mem_load = 1'b1; mon_en = 1'b0; mon_clear = 1'b1;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        set_req(0, 1'b1, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b1, 1'b0, 5'd0, 32'd0);
        tick(3);
        chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_memWrite", {31'd0, bus.mem_memWrite}, 32'd0);
        chk("rst_memRead", {31'd0, bus.mem_memRead}, 32'd0);
        chk("rst_mem_address", {27'd0, bus.mem_address}, 32'd0);
        chk("rst_writeData", bus.mem_writeData, 32'd0);
        chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("rst_rsp0_rdata", bus.rsp0_rdata, 32'd0);
        chk("rst_rsp1_err", {31'd0, bus.rsp1_err}, 32'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 32'd0);
        reset_n = 1'b1; mem_load = 1'b0; mon_clear = 1'b0; mon_en = 1'b1;
        tick(4);

        for (int i = 0; i < 12; i++) begin
            run_single(tbl[i], rd, er, lat, nw, nr, sa, oth);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_write_strobes", i), nw, tbl[i].exp_nw);
            chk($sformatf("vec%0d_read_strobes", i), nr, tbl[i].exp_nr);
            chk($sformatf("vec%0d_other_rsp", i), oth, 0);
            if (tbl[i].exp_nw + tbl[i].exp_nr > 0)
                chk($sformatf("vec%0d_mem_address", i), {27'd0, sa}, {27'd0, tbl[i].addr});
            tick(1);
        end

        // Reset during the ISSUE cycle of a store.
        mon_en = 1'b0;
        drive_req(0, 1'b1, 5'd20, 32'h11111111, w0);
        #2;
        chk("rst5_write_before", {31'd0, bus.mem_memWrite}, 32'd1);
        chk("rst5_addr_before", {27'd0, bus.mem_address}, 32'd20);
        reset_n = 1'b0;
        #1;
        chk("rst5_write_async", {31'd0, bus.mem_memWrite}, 32'd0);
        chk("rst5_read_async", {31'd0, bus.mem_memRead}, 32'd0);
        chk("rst5_addr_async", {27'd0, bus.mem_address}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.rsp0_valid || bus.rsp1_valid) n++;
            @(posedge clock); #1;
        end
        chk("rst5_no_rsp", n, 0);
        chk("rst5_mem_untouched", {dev_mem[23], dev_mem[22], dev_mem[21], dev_mem[20]},
            {init_byte(23), init_byte(22), init_byte(21), init_byte(20)});
        mon_clear = 1'b1;
        tick(1);
        mon_clear = 1'b0;
        mon_en = 1'b1;

        // Both ports streaming loads: grants alternate starting with port 0.
        set_req(0, 1'b1, 1'b0, 5'd8, 32'd0);
        set_req(1, 1'b1, 1'b0, 5'd12, 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (bus.req0_valid && bus.req0_ready) begin gp.push_back(0); gc.push_back(i); end
            if (bus.req1_valid && bus.req1_ready) begin gp.push_back(1); gc.push_back(i); end
            @(posedge clock); #1;
        end
        set_req(0, 1'b0, 1'b0, 5'd8, 32'd0);
        set_req(1, 1'b0, 1'b0, 5'd12, 32'd0);
        chk("alt_count", gp.size(), 8);
        for (int i = 0; i < gp.size(); i++) begin
            chk($sformatf("alt_port%0d", i), gp[i], i % 2);
            if (i > 0) chk($sformatf("alt_gap%0d", i), gc[i] - gc[i-1], 2);
        end
        tick(4);

        // Port 0 waits three cycles behind port 1, then is served exactly once.
        drive_req(0, 1'b0, 5'd0, 32'd0, w0);
        tick(3);
        c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
        fork
            drive_req(0, 1'b0, 5'd8, 32'd0, w0);
            drive_req(1, 1'b0, 5'd12, 32'd0, w1);
        join
        tick(4);
        chk("hold_p1_wait", w1, 1);
        chk("hold_p0_wait", w0, 3);
        chk("hold_p0_rsp_count", rsp_cnt[0] - c0, 1);
        chk("hold_p1_rsp_count", rsp_cnt[1] - c1, 1);

        // Randomised traffic on both ports against the reference model.
        fork
            begin : rand_p0
                logic [4:0] a;
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 3));
                    a = 5'($urandom_range(0, 31));
                    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    drive_req(0, 1'($urandom_range(0, 1)), a, $urandom, w0);
                end
            end
            begin : rand_p1
                logic [4:0] a;
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 3));
                    a = 5'($urandom_range(0, 31));
                    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    drive_req(1, 1'($urandom_range(0, 1)), a, $urandom, w1);
                end
            end
        join
        tick(8);
        chk("drain_q0", q[0].size(), 0);
        chk("drain_q1", q[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
